// File: rtl/rv32imc_types.sv
// Types and line geometry shared by the rv32imc fetch path.
package rv32imc_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } imem_fsm_t;

    localparam int unsigned LINE_BYTES  = 32;
    localparam int unsigned LINE_WORDS  = 8;
    localparam int unsigned BURST_BEATS = 4;
    localparam int unsigned BMEM_WIDTH  = 64;

    localparam int unsigned LINE_BITS   = LINE_WORDS * 32;
    localparam int unsigned OFFSET_BITS = $clog2(LINE_BYTES);
    localparam int unsigned TAG_BITS    = 32 - OFFSET_BITS;

endpackage

// File: rtl/imem_line_responder.sv
// Single-line instruction buffer answering word fetches, refilled by 4-beat bursts.
// Latency: hit 1 cycle; miss returns the cycle after the last beat (min 6 cycles).
// Backpressure: bmem_read held until bmem_ready; beats may be gapped; one fetch in flight.
module imem_line_responder
    import rv32imc_types::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           imem_addr,
    input  logic [3:0]            imem_rmask,
    output logic [31:0]           imem_rdata,
    output logic                  imem_resp,
    input  logic                  i_inval,
    output logic [31:0]           bmem_addr,
    output logic                  bmem_read,
    input  logic                  bmem_ready,
    input  logic [BMEM_WIDTH-1:0] bmem_rdata,
    input  logic                  bmem_rvalid
);

    imem_fsm_t              state, state_nxt;
    logic [LINE_BITS-1:0]   line, line_fill;
    logic [TAG_BITS-1:0]    tag;
    logic                   valid;
    logic                   inval_pend;
    logic [1:0]             beat_cnt;
    logic [29:0]            req_word;
    logic                   req, hit, last_beat;
    logic [31:0]            hit_word, fill_word;
    logic                   unused_addr_bits;

    assign unused_addr_bits = ^imem_addr[1:0];

    // An invalidate in the same cycle as a request forces the miss path.
    assign req       = |imem_rmask;
    assign hit       = valid && !i_inval && (tag == imem_addr[31:OFFSET_BITS]);
    assign last_beat = (state == FILL) && bmem_rvalid && (beat_cnt == 2'd3);
    assign hit_word  = line[{imem_addr[4:2], 5'b0} +: 32];

    // Line as it will look after the current beat, so beat 3 is forwarded.
    always_comb begin
        line_fill = line;
        for (int b = 0; b < BURST_BEATS; b++) begin
            if (beat_cnt == b[1:0])
                line_fill[b*BMEM_WIDTH +: BMEM_WIDTH] = bmem_rdata;
        end
    end

    assign fill_word = line_fill[{req_word[2:0], 5'b0} +: 32];

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req && !hit) state_nxt = REQ;
            REQ:     if (bmem_ready)  state_nxt = FILL;
            FILL:    if (last_beat)   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bmem_read = (state == REQ);
        bmem_addr = {req_word[29:3], 5'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            line       <= '0;
            tag        <= '0;
            valid      <= 1'b0;
            inval_pend <= 1'b0;
            beat_cnt   <= 2'd0;
            req_word   <= '0;
            imem_rdata <= '0;
            imem_resp  <= 1'b0;
        end else begin
            imem_resp <= 1'b0;
            case (state)
                IDLE: begin
                    inval_pend <= 1'b0;
                    if (i_inval)
                        valid <= 1'b0;
                    if (req) begin
                        if (hit) begin
                            imem_rdata <= hit_word;
                            imem_resp  <= 1'b1;
                        end else begin
                            req_word <= imem_addr[31:2];
                        end
                    end
                end
                REQ: begin
                    if (i_inval)
                        inval_pend <= 1'b1;
                    if (bmem_ready)
                        beat_cnt <= 2'd0;
                end
                FILL: begin
                    if (i_inval)
                        inval_pend <= 1'b1;
                    if (bmem_rvalid) begin
                        line     <= line_fill;
                        beat_cnt <= beat_cnt + 2'd1;
                        if (beat_cnt == 2'd3) begin
                            tag        <= req_word[29:3];
                            valid      <= !(inval_pend || i_inval);
                            imem_rdata <= fill_word;
                            imem_resp  <= 1'b1;
                            inval_pend <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_line_responder.sv
// Directed bench for imem_line_responder with a hand-driven burst memory.
module tb_imem_line_responder;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        i_inval;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_ready;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    imem_line_responder dut (
        .clk         (clk),
        .rst         (rst),
        .imem_addr   (imem_addr),
        .imem_rmask  (imem_rmask),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .i_inval     (i_inval),
        .bmem_addr   (bmem_addr),
        .bmem_read   (bmem_read),
        .bmem_ready  (bmem_ready),
        .bmem_rdata  (bmem_rdata),
        .bmem_rvalid (bmem_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [31:0] SALT_A = 32'hA5A5_0000;
    localparam logic [31:0] SALT_B = 32'h0F0F_0000;
    localparam logic [31:0] SALT_C = 32'h00FF_0000;
    localparam logic [31:0] SALT_D = 32'h5A5A_0000;
    localparam logic [31:0] SALT_E = 32'h1234_0000;

    // Word k of a line filled with a given salt.
    function automatic logic [31:0] ew(input logic [31:0] salt, input int k);
        logic [31:0] kk;
        kk = k;
        return (32'h1111_1111 * kk) ^ salt;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input bit inv);
        imem_addr  = a;
        imem_rmask = 4'hF;
        i_inval    = inv;
        step();
        imem_rmask = 4'h0;
        i_inval    = 1'b0;
    endtask

    // Plays the backing memory for one burst; returns with the response cycle current.
    task automatic fill(input logic [31:0] salt, input int stall, input bit gap,
                        input int inval_beat, output bit ok,
                        output logic [31:0] addr, output int nresp);
        int n;
        ok    = 1'b1;
        nresp = 0;
        n     = 0;
        addr  = 32'hDEAD_BEEF;
        while (!bmem_read && n < 20) begin
            step();
            n++;
        end
        if (!bmem_read) begin
            ok = 1'b0;
            return;
        end
        addr = bmem_addr;
        for (int s = 0; s < stall; s++) begin
            bmem_ready = 1'b0;
            step();
            if (!bmem_read) ok = 1'b0;
            nresp += int'(imem_resp);
        end
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        nresp += int'(imem_resp);
        for (int i = 0; i < 4; i++) begin
            if (gap && i > 0) begin
                bmem_rvalid = 1'b0;
                step();
                nresp += int'(imem_resp);
            end
            bmem_rvalid = 1'b1;
            bmem_rdata  = {ew(salt, 2*i+1), ew(salt, 2*i)};
            i_inval     = (i == inval_beat);
            step();
            if (i < 3) nresp += int'(imem_resp);
        end
        bmem_rvalid = 1'b0;
        i_inval     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({imem_resp, bmem_read} !== 2'b00) begin
            errors++;
            $display("FAIL reset_ctrl: resp/read=%b want 00", {imem_resp, bmem_read});
        end
        checks++;
        if (imem_rdata !== 32'h0 || bmem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h want 0/0", imem_rdata, bmem_addr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_cold_miss();
        bit ok;
        logic [31:0] a;
        int nr, t0;
        t0 = cyc;
        issue(32'h0000_1004, 1'b0);
        checks++;
        if (imem_resp !== 1'b0 || bmem_read !== 1'b1) begin
            errors++;
            $display("FAIL cold_req: resp=%b read=%b want 0/1", imem_resp, bmem_read);
        end
        fill(32'h0, 0, 1'b0, -1, ok, a, nr);
        checks++;
        if (!ok || a !== 32'h0000_1000) begin
            errors++;
            $display("FAIL cold_addr: ok=%0b addr=%h want 1/00001000", ok, a);
        end
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== 32'h1111_1111 || nr != 0) begin
            errors++;
            $display("FAIL cold_resp: resp=%b data=%h early=%0d want 1/11111111/0",
                     imem_resp, imem_rdata, nr);
        end
        checks++;
        if (cyc - t0 != 6) begin
            errors++;
            $display("FAIL cold_latency: got %0d cycles want 6", cyc - t0);
        end
        step();
        checks++;
        if (imem_resp !== 1'b0 || imem_rdata !== 32'h1111_1111) begin
            errors++;
            $display("FAIL cold_pulse: resp=%b data=%h want 0/11111111 held", imem_resp, imem_rdata);
        end
        issue(32'h0000_101C, 1'b0);
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== 32'h7777_7777) begin
            errors++;
            $display("FAIL hit_w7: resp=%b data=%h want 1/77777777", imem_resp, imem_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp [3];
        exp[0] = 32'h0000_0000;
        exp[1] = 32'h1111_1111;
        exp[2] = 32'h2222_2222;
        imem_rmask = 4'h1;
        for (int i = 0; i < 3; i++) begin
            imem_addr = 32'h0000_1000 + 32'(4*i);
            step();
            checks++;
            if (imem_resp !== 1'b1 || imem_rdata !== exp[i] || bmem_read !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d: resp=%b data=%h read=%b want 1/%h/0",
                         i, imem_resp, imem_rdata, bmem_read, exp[i]);
            end
        end
        imem_rmask = 4'h0;
        step();
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: resp=%b want 0", imem_resp);
        end
    endtask

    task automatic test_conflict_miss();
        bit ok;
        logic [31:0] a;
        int nr;
        issue(32'h0000_2010, 1'b0);
        fill(SALT_A, 0, 1'b0, -1, ok, a, nr);
        checks++;
        if (!ok || a !== 32'h0000_2000 || imem_resp !== 1'b1 || imem_rdata !== ew(SALT_A, 4)) begin
            errors++;
            $display("FAIL conflict_fill: ok=%0b addr=%h resp=%b data=%h want 1/00002000/1/%h",
                     ok, a, imem_resp, imem_rdata, ew(SALT_A, 4));
        end
        step();
        issue(32'h0000_1000, 1'b0);
        checks++;
        if (imem_resp !== 1'b0 || bmem_read !== 1'b1) begin
            errors++;
            $display("FAIL conflict_remiss: resp=%b read=%b want 0/1", imem_resp, bmem_read);
        end
        fill(SALT_B, 0, 1'b0, -1, ok, a, nr);
        checks++;
        if (!ok || a !== 32'h0000_1000 || imem_rdata !== ew(SALT_B, 0)) begin
            errors++;
            $display("FAIL conflict_refill: ok=%0b addr=%h data=%h want 1/00001000/%h",
                     ok, a, imem_rdata, ew(SALT_B, 0));
        end
        step();
    endtask

    task automatic test_invalidate();
        bit ok;
        logic [31:0] a;
        int nr;
        issue(32'h0000_1000, 1'b1);
        checks++;
        if (imem_resp !== 1'b0 || bmem_read !== 1'b1) begin
            errors++;
            $display("FAIL inval_req: resp=%b read=%b want 0/1", imem_resp, bmem_read);
        end
        fill(SALT_C, 0, 1'b0, 1, ok, a, nr);
        checks++;
        if (!ok || imem_resp !== 1'b1 || imem_rdata !== ew(SALT_C, 0)) begin
            errors++;
            $display("FAIL inval_fill: ok=%0b resp=%b data=%h want 1/1/%h",
                     ok, imem_resp, imem_rdata, ew(SALT_C, 0));
        end
        step();
        issue(32'h0000_1008, 1'b0);
        checks++;
        if (imem_resp !== 1'b0 || bmem_read !== 1'b1) begin
            errors++;
            $display("FAIL inval_pend_miss: resp=%b read=%b want 0/1", imem_resp, bmem_read);
        end
        fill(SALT_C, 0, 1'b0, -1, ok, a, nr);
        checks++;
        if (!ok || imem_rdata !== ew(SALT_C, 2)) begin
            errors++;
            $display("FAIL inval_refill: ok=%0b data=%h want 1/%h", ok, imem_rdata, ew(SALT_C, 2));
        end
        step();
        issue(32'h0000_100C, 1'b0);
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== ew(SALT_C, 3)) begin
            errors++;
            $display("FAIL inval_rehit: resp=%b data=%h want 1/%h", imem_resp, imem_rdata, ew(SALT_C, 3));
        end
        step();
    endtask

    task automatic test_stalls_gaps();
        bit ok;
        logic [31:0] a;
        int nr;
        issue(32'h0000_3018, 1'b0);
        fill(SALT_D, 5, 1'b1, -1, ok, a, nr);
        checks++;
        if (!ok || a !== 32'h0000_3000) begin
            errors++;
            $display("FAIL stall_read_held: ok=%0b addr=%h want 1/00003000", ok, a);
        end
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== ew(SALT_D, 6) || nr != 0) begin
            errors++;
            $display("FAIL gap_data: resp=%b data=%h early=%0d want 1/%h/0",
                     imem_resp, imem_rdata, nr, ew(SALT_D, 6));
        end
        step();
        checks++;
        if (imem_resp !== 1'b0) begin
            errors++;
            $display("FAIL gap_single_resp: resp=%b want 0", imem_resp);
        end
        issue(32'h0000_3000, 1'b0);
        checks++;
        if (imem_resp !== 1'b1 || imem_rdata !== ew(SALT_D, 0)) begin
            errors++;
            $display("FAIL gap_hit: resp=%b data=%h want 1/%h", imem_resp, imem_rdata, ew(SALT_D, 0));
        end
        step();
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        logic [31:0] a;
        int nr;
        issue(32'h0000_4004, 1'b0);
        bmem_ready = 1'b1;
        step();
        bmem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bmem_rvalid = 1'b1;
            bmem_rdata  = {ew(32'hFFFF_0000, 2*i+1), ew(32'hFFFF_0000, 2*i)};
            step();
        end
        bmem_rvalid = 1'b0;
        rst = 1'b1;
        step();
        checks++;
        if ({imem_resp, bmem_read} !== 2'b00 || imem_rdata !== 32'h0 || bmem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midfill_reset: resp=%b read=%b data=%h addr=%h want all 0",
                     imem_resp, bmem_read, imem_rdata, bmem_addr);
        end
        rst = 1'b0;
        step();
        issue(32'h0000_4004, 1'b0);
        checks++;
        if (imem_resp !== 1'b0 || bmem_read !== 1'b1) begin
            errors++;
            $display("FAIL midfill_refetch: resp=%b read=%b want 0/1", imem_resp, bmem_read);
        end
        fill(SALT_E, 0, 1'b0, -1, ok, a, nr);
        checks++;
        if (!ok || a !== 32'h0000_4000 || imem_rdata !== ew(SALT_E, 1)) begin
            errors++;
            $display("FAIL midfill_data: ok=%0b addr=%h data=%h want 1/00004000/%h",
                     ok, a, imem_rdata, ew(SALT_E, 1));
        end
        step();
    endtask

    initial begin
        rst         = 1'b1;
        imem_addr   = 32'h0;
        imem_rmask  = 4'h0;
        i_inval     = 1'b0;
        bmem_ready  = 1'b0;
        bmem_rdata  = 64'h0;
        bmem_rvalid = 1'b0;
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict_miss();
        test_invalidate();
        test_stalls_gaps();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
